// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with a clear sweep
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clr_req,
    output logic                  ready,
    output logic                  clr_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   clr_ptr, clr_ptr_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_RST;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            ST_RST: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
            ST_CLEAR: begin
                clr_ptr_next = clr_ptr + 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = ST_RST;
                clr_ptr_next = '0;
            end
        endcase
    end

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

    // The sweep owns the single memory write port; a clear request beats a write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end else if (state == ST_READY && !clr_req && we && !wr_zero) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready    = (state == ST_READY);
    assign clr_busy = (state == ST_CLEAR);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (!ready) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && we && (wr_addr == addr)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp (bypass and no-bypass builds)
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        ready_b, ready_n, busy_b, busy_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
        .ready(ready_b), .clr_busy(busy_b)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
        .ready(ready_n), .clr_busy(busy_n)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] n0;
        logic [31:0] n1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_to_ready(input string name);
        int n;
        n = 0;
        while (!ready_b && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_len"}, n, 32);
        chk({name, "_ready_n"}, {31'd0, ready_n}, 32'd1);
        chk({name, "_busy_done"}, {30'd0, busy_b, busy_n}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            if (rd_data_b !== 64'd0 || rd_data_n !== 64'd0) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd8,  32'hA5A5A5A5, 5'd8,  5'd0,  32'hA5A5A5A5, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd8,  32'h12345678, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd30, 32'h00000001, 32'h0,        32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd31, 32'h00000BAD, 5'd31, 5'd31, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
        vecs[8] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd7,  32'h11111111, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[9] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd8,  32'h11111111, 32'hA5A5A5A5, 32'h11111111, 32'hA5A5A5A5};

        reset = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
        rd_addr = {5'd3, 5'd9};
        repeat (3) tick();
        chk("rst_flags", {30'd0, ready_b, busy_b}, 32'd0);
        chk("rst_rd_b", rd_data_b[31:0] | rd_data_b[63:32], 32'd0);
        chk("rst_rd_n", rd_data_n[31:0] | rd_data_n[63:32], 32'd0);

        reset = 1'b1;
        tick();
        chk("sweep_first_edge", {30'd0, ready_b, busy_b}, 32'd1);
        count_to_ready("reset_sweep");
        check_all_zero("reset_sweep_zero");

        for (int i = 0; i < 10; i++) begin
            we = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #3;
            chk($sformatf("vec%0d_byp_p0", i), rd_data_b[31:0],  vecs[i].b0);
            chk($sformatf("vec%0d_byp_p1", i), rd_data_b[63:32], vecs[i].b1);
            chk($sformatf("vec%0d_nb_p0", i),  rd_data_n[31:0],  vecs[i].n0);
            chk($sformatf("vec%0d_nb_p1", i),  rd_data_n[63:32], vecs[i].n1);
            tick();
        end

        // fill r1..r31 with their index, then collide a write with clr_req
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
            tick();
        end
        we = 1'b0;
        rd_addr = {5'd31, 5'd17};
        #1;
        chk("fill_r17", rd_data_n[31:0], 32'd17);
        chk("fill_r31", rd_data_n[63:32], 32'd31);

        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; clr_req = 1'b1;
        tick();
        chk("clr_edge_flags", {30'd0, ready_b, busy_b}, 32'd1);
        wr_addr = 5'd4; wr_data = 32'h44444444;
        rd_addr = {5'd4, 5'd17};
        #1;
        chk("clr_masked_rd", rd_data_b[31:0] | rd_data_b[63:32], 32'd0);
        tick();
        clr_req = 1'b0;
        begin
            int n;
            n = 1;
            while (!ready_b && n < 40) begin
                tick();
                n++;
            end
            chk("clr_busy_len", n, 32);
        end
        we = 1'b0; clr_req = 1'b0;
        check_all_zero("clr_sweep_zero");
        tick();
        chk("clr_not_queued", {30'd0, ready_b, busy_b}, 32'd2);

        // reset while the sweep sits at entry 10
        rd_addr = {5'd6, 5'd2};
        we = 1'b1; wr_addr = 5'd2; wr_data = 32'h22222222;
        tick();
        we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        chk("mid_busy", {31'd0, busy_b}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_flags", {28'd0, ready_b, busy_b, ready_n, busy_n}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_first_edge", {31'd0, busy_b}, 32'd1);
        count_to_ready("mid_sweep");
        check_all_zero("mid_sweep_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the decode stage: DATA_W-bit entries, 2^ADDR_W deep, NRD combinational read ports, and one synchronous write port with optional same-cycle write-to-read bypass. Contents are not cleared in one cycle. A clear sequencer zeroes one entry per clock after reset or on request, and holds `ready` low until the sweep completes. Decode reads operands from this block and writeback drives its write port. Upstream stalls while `ready` is low.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  request a full clear sweep; sampled only while ready=1
- ready  out  1  1 = sweep complete, and writes are accepted
- clr_busy  out  1  1 = clear sweep in progress

## Operation
- States:
  - RST: reset low.
  - CLEAR: sweep in progress.
  - READY: normal operation.
- RST:
  - Entered on any edge with reset=0, from any state.
  - clr_ptr <= 0, ready=0, clr_busy=0.
  - Memory is not written in this state.
- RST -> CLEAR on the first edge with reset=1.
- CLEAR, each edge:
  - mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1.
  - On the edge that clears entry DEPTH-1, go to READY.
  - clr_ptr wraps to 0.
- READY:
  - Edge with clr_req=1: go to CLEAR with clr_ptr=0; any write in that cycle is dropped (clear has priority).
  - Edge with we=1, clr_req=0: mem[wr_addr] <= wr_data, unless ZERO_REG=1 and wr_addr=0.
- Writes with ready=0 are dropped silently. Upstream must stall.
- Reads are combinational, evaluated per port k, in this priority order:
  1. ready=0: rd_data[k] = 0.
  2. ZERO_REG=1 and rd_addr[k]=0: output 0.
  3. BYPASS=1, we=1 and wr_addr=rd_addr[k]: output wr_data.
  4. Otherwise: output mem[rd_addr[k]].
- Multiple ports may read the same address; each gets identical data.
- Outputs:
  - ready = (state==READY).
  - clr_busy = (state==CLEAR).
  - Both are registered state decodes and glitch-free.

## Timing
- Write latency: 1 edge. With BYPASS=0, data is visible on reads from the cycle after the write edge.
- Read latency: 0 cycles (combinational from rd_addr, and from we/wr_addr/wr_data when BYPASS=1).
- Reset values:
  - While reset=0: ready=0, clr_busy=0, rd_data=0.
  - Memory contents are undefined until the sweep completes; reads are masked to 0.
- Sweep length: DEPTH edges.
  - ready rises after the (DEPTH)th edge following the first edge with reset=1.
  - With DEPTH=32, that is 32 edges after reset release.
- clr_req sweep: clr_busy rises after the clr_req edge; ready falls on that same edge and rises DEPTH edges later.
- Reset low mid-sweep: return to RST and restart from entry 0 when released. Partially cleared state is discarded.
- clr_req while ready=0 is ignored. It is not queued.

## Test plan
- Reset sweep:
  - Stimulus: hold reset=0 for 3 edges, release, DATA_W=32, ADDR_W=5.
  - Required: ready=0 for exactly 32 edges, then ready=1.
  - Required: all 32 addresses read 0x00000000 afterwards.
- Write/read with BYPASS=0:
  - Stimulus: write 0xDEADBEEF to r5.
  - Required: r5 reads the old value (0) in the write cycle and 0xDEADBEEF the next cycle.
  - Required: ports 0 and 1 both addressing r5 return the same value.
- Bypass with BYPASS=1:
  - Stimulus: we=1, wr_addr=7, wr_data=0x12345678, rd_addr[0]=7 in the same cycle.
  - Required: rd_data[0]=0x12345678 combinationally.
  - Required: rd_addr[1]=8 returns mem[8], unaffected.
- Zero register with ZERO_REG=1:
  - Stimulus: write 0xFFFFFFFF to r0 with BYPASS=1 and rd_addr[0]=0.
  - Required: r0 reads 0 in the write cycle and after it.
- clr_req and drops:
  - Stimulus: fill r1..r31 with their index, assert clr_req and we in the same cycle.
  - Required: the write is dropped and clr_busy=1 for 32 cycles.
  - Required: writes during the sweep are dropped, and all entries read 0 once ready=1.
- Reset mid-sweep:
  - Stimulus: drive reset=0 at sweep entry 10, then release.
  - Required: the sweep restarts at entry 0 and ready rises exactly 32 edges after release.
